// File: rtl/nibble_serial_tx_pkg.sv
// Shared definitions for the nibble serial transmitter: state encodings,
// line levels and a counter-width helper.
package nibble_tx_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;
  localparam logic TX_STOP  = 1'b1;

  // A one-cycle bit period still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_tx_if.sv
// Load/ready handshake and serial-line bundle between the data registers
// and the nibble transmitter.
interface nibble_serial_tx_if #(
  parameter int DATA_W = 4
);
  logic [DATA_W-1:0] D;
  logic              load;
  logic              ready;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (output D, load, input ready, tx, busy, done);
  modport slave  (input D, load, output ready, tx, busy, done);
endinterface

// File: rtl/nibble_serial_tx_bit_period_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each serial bit; tick_nxt flags that the coming cycle will be the last.
module bit_period_counter
  import nibble_tx_defs::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic tick_nxt
);
  localparam int            CW   = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick     = (cnt_q == LAST);
  assign tick_nxt = (cnt_d == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
endmodule

// File: rtl/nibble_serial_tx.sv
// Nibble serial transmitter: start bit, DATA_W data bits LSB-first, stop bit.
// Define NIBBLE_TX_PARITY_EN to insert an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, ready for a load
// START  | start bit (low) for one bit period
// DATA   | shift[0] on the line, one bit period per data bit
// PARITY | even parity of the captured word (parity build only)
// STOP   | stop bit (high); done on its final cycle
module nibble_serial_tx
  import nibble_tx_defs::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input logic               clk,
  input logic               reset_n,
  nibble_serial_tx_if.slave bus
);
  localparam int            BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick, tick_nxt;
`ifdef NIBBLE_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  bit_period_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_period_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_q == IDLE),
    .enable   (state_q != IDLE),
    .tick     (tick),
    .tick_nxt (tick_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= TX_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef NIBBLE_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef NIBBLE_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: if (bus.load) begin
        shift_d = bus.D;
        state_d = START;
`ifdef NIBBLE_TX_PARITY_EN
        parity_d = ^bus.D;
`endif
      end
      START: if (tick) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (tick) begin
        shift_d = shift_q >> 1;
        if (bit_cnt_q == LAST_BIT) begin
`ifdef NIBBLE_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
`ifdef NIBBLE_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && tick_nxt;
    case (state_d)
      START:   tx_d = TX_START;
      DATA:    tx_d = shift_d[0];
`ifdef NIBBLE_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      STOP:    tx_d = TX_STOP;
      default: tx_d = TX_IDLE;
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench for nibble_serial_tx: two instances with different bit
// periods, each with a per-cycle expected line/done queue.
module tb_nibble_serial_tx;
`ifdef NIBBLE_TX_PARITY_EN
  localparam int NBITS = 7;
  localparam int CPB_B = 2;
`else
  localparam int NBITS = 6;
  localparam int CPB_B = 1;
`endif
  localparam int CPB_A = 4;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb, pa, pb;
  logic idle_a = 1'b0;
  logic idle_b = 1'b0;

  nibble_serial_tx_if #(.DATA_W(4)) if_a ();
  nibble_serial_tx_if #(.DATA_W(4)) if_b ();

  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a)
  );
  nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Line level of frame bit b: start, data LSB-first, optional parity, stop.
  function automatic logic frame_level(input logic [3:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 4) return d[b-1];
`ifdef NIBBLE_TX_PARITY_EN
    if (b == 5) return ^d;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) sb_a.delete();
    else if (if_a.load && idle_a)
      for (int b = 0; b < NBITS; b++)
        for (int c = 0; c < CPB_A; c++) begin
          pa.tx   = frame_level(if_a.D, b);
          pa.done = (b == NBITS-1) && (c == CPB_A-1);
          sb_a.push_back(pa);
        end
    #1;
    if (sb_a.size() != 0) begin
      ea = sb_a.pop_front();
      check_val("a_tx",    if_a.tx,    ea.tx);
      check_val("a_done",  if_a.done,  ea.done);
      check_val("a_busy",  if_a.busy,  1);
      check_val("a_ready", if_a.ready, 0);
      idle_a = 1'b0;
    end else begin
      check_val("a_idle_tx",    if_a.tx,    1);
      check_val("a_idle_done",  if_a.done,  0);
      check_val("a_idle_busy",  if_a.busy,  0);
      check_val("a_idle_ready", if_a.ready, 1);
      idle_a = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (!reset_n) sb_b.delete();
    else if (if_b.load && idle_b)
      for (int b = 0; b < NBITS; b++)
        for (int c = 0; c < CPB_B; c++) begin
          pb.tx   = frame_level(if_b.D, b);
          pb.done = (b == NBITS-1) && (c == CPB_B-1);
          sb_b.push_back(pb);
        end
    #1;
    if (sb_b.size() != 0) begin
      eb = sb_b.pop_front();
      check_val("b_tx",    if_b.tx,    eb.tx);
      check_val("b_done",  if_b.done,  eb.done);
      check_val("b_busy",  if_b.busy,  1);
      check_val("b_ready", if_b.ready, 0);
      idle_b = 1'b0;
    end else begin
      check_val("b_idle_tx",    if_b.tx,    1);
      check_val("b_idle_done",  if_b.done,  0);
      check_val("b_idle_busy",  if_b.busy,  0);
      check_val("b_idle_ready", if_b.ready, 1);
      idle_b = 1'b1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clk       = 1'b0;
    reset_n   = 1'b0;
    if_a.load = 1'b1; if_a.D = 4'hF;
    if_b.load = 1'b1; if_b.D = 4'hF;
    cyc(3);
    reset_n = 1'b1;
    if_a.load = 1'b0;
    if_b.load = 1'b0;
    cyc(2);

    if_a.D = 4'hA; if_a.load = 1'b1; cyc(1); if_a.load = 1'b0;
    cyc(30);

    if_a.D = 4'h3; if_a.load = 1'b1; cyc(1); if_a.load = 1'b0;
    cyc(4);
    if_a.D = 4'hC; if_a.load = 1'b1; cyc(1); if_a.load = 1'b0;
    cyc(30);

    if_b.D = 4'h7; if_b.load = 1'b1; cyc(1); if_b.load = 1'b0;
    cyc(20);
    if_b.D = 4'h5; if_b.load = 1'b1; cyc(30); if_b.load = 1'b0;
    cyc(20);

    if_a.D = 4'h0; if_a.load = 1'b1; cyc(1); if_a.load = 1'b0;
    cyc(9);
    reset_n = 1'b0; cyc(1); reset_n = 1'b1;
    cyc(3);
    if_a.D = 4'h9; if_a.load = 1'b1; cyc(1); if_a.load = 1'b0;
    cyc(30);

    check_val("a_drained", sb_a.size(), 0);
    check_val("b_drained", sb_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
